// File: rtl/pkt_rr_arbiter.sv
// ============================================================================
// Module   : pkt_rr_arbiter
// Purpose  : Two-input whole-packet round-robin arbiter feeding the L4 parser
//            pktin port. Optional statistics counters under PKT_ARB_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
// Synchronous FIFO. The q output is registered and changes only on a read.
// Writes to a full FIFO are discarded.
// ----------------------------------------------------------------------------
module pkt_rr_arbiter_fifo #(
    parameter int W  = 139,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wrreq,
    input  logic [W-1:0]  data,
    input  logic          rdreq,
    output logic [W-1:0]  q,
    output logic [AW:0]   usedw
);
    localparam logic [AW:0] C_DEPTH = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  r_mem [0:(1<<AW)-1];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_cnt;
    logic          w_do_wr;
    logic          w_do_rd;

    assign w_do_wr = wrreq && (r_cnt != C_DEPTH);
    assign w_do_rd = rdreq && (r_cnt != '0);
    assign usedw   = r_cnt;

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            q        <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                q        <= r_mem[r_rd_ptr];
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// ----------------------------------------------------------------------------
// Top level arbiter.
// ----------------------------------------------------------------------------
module pkt_rr_arbiter #(
    parameter int W_PKT      = 139,
    parameter int DATA_AW    = 8,
    parameter int VLD_AW     = 6,
    parameter int RDY_THRESH = 160
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in0_data_wr,
    input  logic [W_PKT-1:0]  in0_data,
    input  logic              in0_data_valid_wr,
    input  logic              in0_data_valid,
    output logic              in0_ready,
    input  logic              in1_data_wr,
    input  logic [W_PKT-1:0]  in1_data,
    input  logic              in1_data_valid_wr,
    input  logic              in1_data_valid,
    output logic              in1_ready,
    output logic              out_data_wr,
    output logic [W_PKT-1:0]  out_data,
    output logic              out_data_valid_wr,
    output logic              out_data_valid,
    input  logic              out_ready
`ifdef PKT_ARB_CNT_EN
    ,
    output logic [31:0]       cnt_pkt0,
    output logic [31:0]       cnt_pkt1,
    output logic [31:0]       cnt_drop0,
    output logic [31:0]       cnt_drop1,
    output logic [15:0]       cnt_ovf
`endif
);
    localparam logic [DATA_AW:0] C_THRESH   = (DATA_AW+1)'(RDY_THRESH);
    localparam logic [VLD_AW:0]  C_VLD_FULL = {1'b1, {VLD_AW{1'b0}}};
    localparam logic [2:0]       C_TAG_TAIL = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_XFER  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]       w_in_wr;
    logic [1:0]       w_in_vwr;
    logic [1:0]       w_in_v;
    logic [W_PKT-1:0] w_in_data [2];
    logic [W_PKT-1:0] w_dat_q   [2];
    logic [DATA_AW:0] w_dat_used[2];
    logic [VLD_AW:0]  w_vld_used[2];
    logic             w_vld_q   [2];
    logic [1:0]       w_pend;
    logic [1:0]       w_vld_full;
    logic [1:0]       w_pop_dat;
    logic [1:0]       w_pop_vld;
    logic             w_grant;
    logic [W_PKT-1:0] w_q_sel;
    logic             w_tail;

    logic [1:0]       r_ready;
    logic             r_sel;
    logic             r_last;
    logic             r_keep;
    logic             r_out_wr;
    logic [W_PKT-1:0] r_out_data;
    logic             r_out_vwr;
    logic             r_out_v;

    assign w_in_wr      = {in1_data_wr, in0_data_wr};
    assign w_in_vwr     = {in1_data_valid_wr, in0_data_valid_wr};
    assign w_in_v       = {in1_data_valid, in0_data_valid};
    assign w_in_data[0] = in0_data;
    assign w_in_data[1] = in1_data;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_in
            pkt_rr_arbiter_fifo #(
                .W  (W_PKT),
                .AW (DATA_AW)
            ) u_dat_fifo (
                .clk   (clk),
                .reset (reset),
                .wrreq (w_in_wr[gi]),
                .data  (w_in_data[gi]),
                .rdreq (w_pop_dat[gi]),
                .q     (w_dat_q[gi]),
                .usedw (w_dat_used[gi])
            );

            pkt_rr_arbiter_fifo #(
                .W  (1),
                .AW (VLD_AW)
            ) u_vld_fifo (
                .clk   (clk),
                .reset (reset),
                .wrreq (w_in_vwr[gi]),
                .data  (w_in_v[gi]),
                .rdreq (w_pop_vld[gi]),
                .q     (w_vld_q[gi]),
                .usedw (w_vld_used[gi])
            );
        end
    endgenerate

    assign w_pend     = {(w_vld_used[1] != '0), (w_vld_used[0] != '0)};
    assign w_vld_full = {(w_vld_used[1] == C_VLD_FULL), (w_vld_used[0] == C_VLD_FULL)};
    assign w_q_sel    = w_dat_q[r_sel];
    assign w_tail     = (w_q_sel[W_PKT-1 -: 3] == C_TAG_TAIL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ready <= 2'b11;
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_ready[i] <= (w_dat_used[i] < C_THRESH) && !w_vld_full[i];
            end
        end
    end

    assign in0_ready = r_ready[0];
    assign in1_ready = r_ready[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // LATCH does not read data: the head word stays on q until XFER consumes it.
    always_comb begin
        w_state_nxt = r_state;
        w_pop_dat   = 2'b00;
        w_pop_vld   = 2'b00;
        w_grant     = (w_pend == 2'b11) ? ~r_last : w_pend[1];
        case (r_state)
            S_IDLE: begin
                if (out_ready && (w_pend != 2'b00)) begin
                    w_pop_vld[w_grant] = 1'b1;
                    w_pop_dat[w_grant] = 1'b1;
                    w_state_nxt        = S_LATCH;
                end
            end
            S_LATCH: begin
                w_state_nxt = S_XFER;
            end
            S_XFER: begin
                if (w_tail) begin
                    w_state_nxt = S_GAP;
                end else begin
                    w_pop_dat[r_sel] = 1'b1;
                end
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel      <= 1'b0;
            r_last     <= 1'b1;
            r_keep     <= 1'b0;
            r_out_wr   <= 1'b0;
            r_out_data <= '0;
            r_out_vwr  <= 1'b0;
            r_out_v    <= 1'b0;
        end else begin
            r_out_wr  <= 1'b0;
            r_out_vwr <= 1'b0;
            r_out_v   <= 1'b0;
            if ((r_state == S_IDLE) && (w_state_nxt == S_LATCH)) begin
                r_sel  <= w_grant;
                r_last <= w_grant;
            end
            if (r_state == S_LATCH) begin
                r_keep <= w_vld_q[r_sel];
            end
            if (r_state == S_XFER) begin
                r_out_data <= w_q_sel;
                r_out_wr   <= r_keep;
                if (w_tail && r_keep) begin
                    r_out_vwr <= 1'b1;
                    r_out_v   <= 1'b1;
                end
            end
        end
    end

    assign out_data_wr       = r_out_wr;
    assign out_data          = r_out_data;
    assign out_data_valid_wr = r_out_vwr;
    assign out_data_valid    = r_out_v;

`ifdef PKT_ARB_CNT_EN
    localparam logic [DATA_AW:0] C_DATA_FULL = {1'b1, {DATA_AW{1'b0}}};

    logic [31:0] r_cnt_pkt  [2];
    logic [31:0] r_cnt_drop [2];
    logic [15:0] r_cnt_ovf;
    logic [1:0]  w_ovf_dat;
    logic [1:0]  w_ovf_vld;
    logic        w_end_pkt;

    assign w_ovf_dat = {(in1_data_wr && (w_dat_used[1] == C_DATA_FULL)),
                        (in0_data_wr && (w_dat_used[0] == C_DATA_FULL))};
    assign w_ovf_vld = w_in_vwr & w_vld_full;
    assign w_end_pkt = (r_state == S_XFER) && w_tail;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt_pkt[0]  <= '0;
            r_cnt_pkt[1]  <= '0;
            r_cnt_drop[0] <= '0;
            r_cnt_drop[1] <= '0;
            r_cnt_ovf     <= '0;
        end else begin
            if (w_end_pkt && r_keep) begin
                r_cnt_pkt[r_sel] <= r_cnt_pkt[r_sel] + 32'd1;
            end
            if (w_end_pkt && !r_keep) begin
                r_cnt_drop[r_sel] <= r_cnt_drop[r_sel] + 32'd1;
            end
            r_cnt_ovf <= r_cnt_ovf + 16'(w_ovf_dat[0]) + 16'(w_ovf_dat[1])
                                   + 16'(w_ovf_vld[0]) + 16'(w_ovf_vld[1]);
        end
    end

    assign cnt_pkt0  = r_cnt_pkt[0];
    assign cnt_pkt1  = r_cnt_pkt[1];
    assign cnt_drop0 = r_cnt_drop[0];
    assign cnt_drop1 = r_cnt_drop[1];
    assign cnt_ovf   = r_cnt_ovf;
`endif
endmodule

`default_nettype wire

// File: tb/tb_pkt_rr_arbiter.sv
// ============================================================================
// Module   : tb_pkt_rr_arbiter
// Purpose  : Self-checking bench for pkt_rr_arbiter with a packet-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pkt_rr_arbiter;
    logic         clk;
    logic         reset;
    logic         in0_data_wr;
    logic [138:0] in0_data;
    logic         in0_data_valid_wr;
    logic         in0_data_valid;
    logic         in0_ready;
    logic         in1_data_wr;
    logic [138:0] in1_data;
    logic         in1_data_valid_wr;
    logic         in1_data_valid;
    logic         in1_ready;
    logic         out_data_wr;
    logic [138:0] out_data;
    logic         out_data_valid_wr;
    logic         out_data_valid;
    logic         out_ready;
`ifdef PKT_ARB_CNT_EN
    logic [31:0]  cnt_pkt0;
    logic [31:0]  cnt_pkt1;
    logic [31:0]  cnt_drop0;
    logic [31:0]  cnt_drop1;
    logic [15:0]  cnt_ovf;
`endif

    pkt_rr_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .in0_data_wr       (in0_data_wr),
        .in0_data          (in0_data),
        .in0_data_valid_wr (in0_data_valid_wr),
        .in0_data_valid    (in0_data_valid),
        .in0_ready         (in0_ready),
        .in1_data_wr       (in1_data_wr),
        .in1_data          (in1_data),
        .in1_data_valid_wr (in1_data_valid_wr),
        .in1_data_valid    (in1_data_valid),
        .in1_ready         (in1_ready),
        .out_data_wr       (out_data_wr),
        .out_data          (out_data),
        .out_data_valid_wr (out_data_valid_wr),
        .out_data_valid    (out_data_valid),
        .out_ready         (out_ready)
`ifdef PKT_ARB_CNT_EN
        ,
        .cnt_pkt0          (cnt_pkt0),
        .cnt_pkt1          (cnt_pkt1),
        .cnt_drop0         (cnt_drop0),
        .cnt_drop1         (cnt_drop1),
        .cnt_ovf           (cnt_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Packet model: per-input pending packets (words, length, good flag) and the
    // word stream expected on the output for the packet currently being sent.
    logic [138:0] mw0[$];
    logic [138:0] mw1[$];
    int           ml0[$];
    int           ml1[$];
    bit           mg0[$];
    bit           mg1[$];
    logic [138:0] exp_q[$];
    bit           m_last    = 1'b1;
    bit           prev_tail = 1'b0;
    int           fwd0      = 0;
    int           fwd1      = 0;

    task automatic chk(input string name, input logic [138:0] act, input logic [138:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [138:0] mk(input int port, input int id, input int idx, input int n);
        logic [2:0] tag;
        tag = (idx == n - 1) ? 3'b110 : ((idx == 0) ? 3'b101 : 3'b100);
        return {tag, 104'd0, 8'(port), 8'(id), 16'(idx)};
    endfunction

    // Round-robin choice at packet granularity; bad packets consume a grant silently.
    task automatic model_pick();
        bit p0, p1, sel, g;
        int len;
        logic [138:0] w;
        while ((exp_q.size() == 0) && ((ml0.size() > 0) || (ml1.size() > 0))) begin
            p0  = (ml0.size() > 0);
            p1  = (ml1.size() > 0);
            sel = (p0 && p1) ? ~m_last : p1;
            m_last = sel;
            if (!sel) begin
                len = ml0.pop_front();
                g   = mg0.pop_front();
                for (int k = 0; k < len; k++) begin
                    w = mw0.pop_front();
                    if (g) exp_q.push_back(w);
                end
                if (g) fwd0++;
            end else begin
                len = ml1.pop_front();
                g   = mg1.pop_front();
                for (int k = 0; k < len; k++) begin
                    w = mw1.pop_front();
                    if (g) exp_q.push_back(w);
                end
                if (g) fwd1++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mw0.delete(); mw1.delete(); ml0.delete(); ml1.delete();
            mg0.delete(); mg1.delete(); exp_q.delete();
            m_last    = 1'b1;
            prev_tail = 1'b0;
        end else begin
            if (out_data_valid_wr && !out_data_wr) begin
                chk("vstrobe_without_word", {138'd0, out_data_valid_wr}, 139'd0);
            end
            if (out_data_wr) begin
                if (prev_tail) chk("inter_packet_gap", {138'd0, out_data_wr}, 139'd0);
                if (exp_q.size() == 0) model_pick();
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", out_data, 139'd0);
                    prev_tail = 1'b0;
                end else begin
                    logic [138:0] w;
                    bit last;
                    w    = exp_q.pop_front();
                    last = (exp_q.size() == 0);
                    chk("out_word", out_data, w);
                    chk("valid_strobe", {137'd0, out_data_valid_wr, out_data_valid},
                        last ? 139'd3 : 139'd0);
                    prev_tail = last;
                end
            end else begin
                if (exp_q.size() > 0) begin
                    chk("packet_stalled", {138'd0, out_data_wr}, 139'd1);
                    exp_q.delete();
                end
                prev_tail = 1'b0;
            end
        end
    end

    task automatic clr_inputs();
        in0_data_wr = 0; in0_data_valid_wr = 0; in0_data_valid = 0;
        in1_data_wr = 0; in1_data_valid_wr = 0; in1_data_valid = 0;
    endtask

    task automatic send_pkt(input int port, input int n, input bit good, input int id);
        logic [138:0] w;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            w = mk(port, id, i, n);
            if (port == 0) begin
                in0_data_wr = 1; in0_data = w;
                in0_data_valid_wr = (i == n - 1); in0_data_valid = good && (i == n - 1);
                mw0.push_back(w);
                if (i == n - 1) begin ml0.push_back(n); mg0.push_back(good); end
            end else begin
                in1_data_wr = 1; in1_data = w;
                in1_data_valid_wr = (i == n - 1); in1_data_valid = good && (i == n - 1);
                mw1.push_back(w);
                if (i == n - 1) begin ml1.push_back(n); mg1.push_back(good); end
            end
        end
        @(posedge clk); #1;
        clr_inputs();
    endtask

    task automatic write_raw(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in0_data_wr = 1;
            in0_data    = mk(0, 99, i, 1000);
        end
        @(posedge clk); #1;
        clr_inputs();
    endtask

    task automatic wait_word(output int lat);
        lat = 0;
        while (!out_data_wr && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (((ml0.size() + ml1.size() + exp_q.size()) > 0) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (8) @(posedge clk);
        #1;
        chk(name, {138'd0, (t >= 3000)}, 139'd0);
    endtask

    task automatic pulse_reset();
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        int nwr;
        clr_inputs();
        in0_data = '0; in1_data = '0;
        out_ready = 0;
        reset = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_data_wr", {138'd0, out_data_wr}, 139'd0);
        chk("rst_out_data", out_data, 139'd0);
        chk("rst_out_vwr", {138'd0, out_data_valid_wr}, 139'd0);
        chk("rst_out_v", {138'd0, out_data_valid}, 139'd0);
        chk("rst_in0_ready", {138'd0, in0_ready}, 139'd1);
        chk("rst_in1_ready", {138'd0, in1_ready}, 139'd1);
        reset = 1;
        @(posedge clk); #1;

        // Single 4-word packet: grant in the cycle after the strobe edge, head 3 cycles later.
        out_ready = 1;
        send_pkt(0, 4, 1, 1);
        wait_word(lat);
        chk("t1_latency", 139'(lat), 139'd3);
        chk("t1_head", out_data, {3'b101, 104'd0, 8'd0, 8'd1, 16'd0});
        wait_drain("t1_drain");
        chk("t1_fwd0", 139'(fwd0), 139'd1);
`ifdef PKT_ARB_CNT_EN
        chk("t1_cnt_pkt0", 139'(cnt_pkt0), 139'd1);
`endif

        // Bad packet sandwiched between two good ones on in1.
        out_ready = 0;
        send_pkt(1, 3, 1, 10);
        send_pkt(1, 2, 0, 11);
        send_pkt(1, 4, 1, 12);
        out_ready = 1;
        wait_drain("t3_drain");
        chk("t3_fwd1", 139'(fwd1), 139'd2);
`ifdef PKT_ARB_CNT_EN
        chk("t3_cnt_drop1", 139'(cnt_drop1), 139'd1);
        chk("t3_cnt_pkt1", 139'(cnt_pkt1), 139'd2);
`endif
        send_pkt(0, 3, 1, 13);
        wait_drain("t3_after_drop");
        chk("t3_fwd0", 139'(fwd0), 139'd2);
        send_pkt(1, 1, 1, 14);
        wait_drain("single_word");
        chk("single_fwd1", 139'(fwd1), 139'd3);

        // Three packets on each input, pending together; last grant was in1.
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            send_pkt(0, 3, 1, 20 + k);
            send_pkt(1, 2, 1, 30 + k);
        end
        out_ready = 1;
        wait_word(lat);
        chk("t2_first_head", out_data, {3'b101, 104'd0, 8'd0, 8'd20, 16'd0});
        wait_drain("t2_drain");
        chk("t2_fwd0", 139'(fwd0), 139'd5);
        chk("t2_fwd1", 139'(fwd1), 139'd6);

        // out_ready low holds grants; dropping it mid-packet does not stall.
        out_ready = 0;
        send_pkt(0, 5, 1, 40);
        send_pkt(1, 3, 1, 41);
        nwr = 0;
        repeat (10) begin
            @(posedge clk); #1;
            nwr += out_data_wr;
        end
        chk("t4_quiet_while_low", 139'(nwr), 139'd0);
        out_ready = 1;
        wait_word(lat);
        chk("t4_latency", 139'(lat), 139'd3);
        out_ready = 0;
        nwr = 1;
        repeat (20) begin
            @(posedge clk); #1;
            nwr += out_data_wr;
        end
        chk("t4_words_while_low", 139'(nwr), 139'd5);
        out_ready = 1;
        wait_drain("t4_drain");

        // Ready threshold and overflow.
        out_ready = 0;
        write_raw(159);
        repeat (2) @(posedge clk);
        #1;
        chk("t5_ready_159", {138'd0, in0_ready}, 139'd1);
        write_raw(1);
        repeat (2) @(posedge clk);
        #1;
        chk("t5_ready_160", {138'd0, in0_ready}, 139'd0);
        chk("t5_in1_ready", {138'd0, in1_ready}, 139'd1);
        write_raw(10);
`ifdef PKT_ARB_CNT_EN
        write_raw(91);
        repeat (2) @(posedge clk);
        #1;
        chk("t5_cnt_ovf", 139'(cnt_ovf), 139'd5);
`endif
        pulse_reset();
        chk("t5_ready_after_rst", {138'd0, in0_ready}, 139'd1);

        // Reset in the middle of a 10-word packet.
        out_ready = 1;
        send_pkt(0, 10, 1, 50);
        wait_word(lat);
        chk("t6_started", {138'd0, out_data_wr}, 139'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        #1;
        chk("t6_rst_wr", {138'd0, out_data_wr}, 139'd0);
        chk("t6_rst_data", out_data, 139'd0);
        chk("t6_rst_vwr", {137'd0, out_data_valid_wr, out_data_valid}, 139'd0);
        chk("t6_rst_ready", {137'd0, in1_ready, in0_ready}, 139'd3);
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk); #1;
        out_ready = 0;
        send_pkt(1, 2, 1, 61);
        send_pkt(0, 2, 1, 60);
        out_ready = 1;
        wait_word(lat);
        chk("t6_first_tie_in0", out_data, {3'b101, 104'd0, 8'd0, 8'd60, 16'd0});
        wait_drain("t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
